// File: rtl/univ_shift_reg_ctl.sv
// -----------------------------------------------------------------------------
// univ_shift_reg_ctl
//
// Universal shift register with a built-in burst controller. One-shot
// operations run while IDLE whenever en is high. A start/count request runs
// an N-step shift or rotate on its own, one step per clock, with busy/done
// status.
//
// Ports
//   clk    in   rising-edge clock for all state
//   rstn   in   asynchronous active-low reset
//   mode   in   3-bit op select:
//                 000 hold, 001 shl, 010 shr, 011 rol, 100 ror,
//                 101 asr, 110 load, 111 hold
//   en     in   single-step enable (IDLE only)
//   start  in   burst request (IDLE only)
//   count  in   burst length, captured together with start
//   I      in   parallel load data
//   SIL    in   serial input for shl (enters A[0])
//   SIR    in   serial input for shr (enters A[WIDTH-1])
//   A      out  register contents
//   SOL    out  A[WIDTH-1], combinational
//   SOR    out  A[0], combinational
//   busy   out  high while a burst is running
//   done   out  one-cycle pulse after a burst completes
// -----------------------------------------------------------------------------
module univ_shift_reg_ctl #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [2:0]       mode,
  input  logic             en,
  input  logic             start,
  input  logic [CNT_W-1:0] count,
  input  logic [WIDTH-1:0] I,
  input  logic             SIL,
  input  logic             SIR,
  output logic [WIDTH-1:0] A,
  output logic             SOL,
  output logic             SOR,
  output logic             busy,
  output logic             done
);

  typedef enum logic [2:0] {
    OP_HOLD = 3'b000,
    OP_SHL  = 3'b001,
    OP_SHR  = 3'b010,
    OP_ROL  = 3'b011,
    OP_ROR  = 3'b100,
    OP_ASR  = 3'b101,
    OP_LOAD = 3'b110,
    OP_RSVD = 3'b111
  } op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  op_e              mode_q, mode_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             burst_op;
  logic             last_step;

  // Next value of the register for a given op. Load is included so the
  // single-step path and the burst path share one datapath. Burst mode is
  // never load, so I is effectively unused while RUN.
  function automatic logic [WIDTH-1:0] apply_op(
    input logic [2:0]       op,
    input logic [WIDTH-1:0] a,
    input logic [WIDTH-1:0] load_val,
    input logic             sil,
    input logic             sir
  );
    logic [WIDTH-1:0] r;
    r = a;
    case (op)
      OP_SHL:  r = {a[WIDTH-2:0], sil};
      OP_SHR:  r = {sir, a[WIDTH-1:1]};
      OP_ROL:  r = {a[WIDTH-2:0], a[WIDTH-1]};
      OP_ROR:  r = {a[0], a[WIDTH-1:1]};
      OP_ASR:  r = {a[WIDTH-1], a[WIDTH-1:1]};
      OP_LOAD: r = load_val;
      default: r = a;  // hold and reserved encoding
    endcase
    return r;
  endfunction

  // Only the five shift/rotate ops can be run as a burst. Start with any
  // other mode is ignored, and en is then evaluated as usual.
  assign burst_op  = (mode != OP_HOLD) && (mode <= OP_ASR);

  // The step that consumes the final remaining count also leaves RUN.
  assign last_step = (cnt_q == CNT_W'(1));

  // ---------------------------------------------------------------------------
  // Next-state and datapath
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable gets a default first so that no path through the
    // case/if tree leaves it unassigned, which would infer a latch.
    state_d = state_q;
    a_d     = a_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start && burst_op) begin
          // A valid start wins over en. A is left untouched this cycle and
          // the first shift happens on the following edge.
          if (count != '0) begin
            state_d = ST_RUN;
            cnt_d   = count;
            mode_d  = op_e'(mode);
            busy_d  = 1'b1;
          end else begin
            // A zero-length burst completes at once.
            done_d = 1'b1;
          end
        end else if (en) begin
          a_d = apply_op(mode, a_q, I, SIL, SIR);
        end
      end

      ST_RUN: begin
        // Inputs other than SIL/SIR are ignored here. The serial inputs are
        // sampled live on every shift edge.
        a_d   = apply_op(mode_q, a_q, I, SIL, SIR);
        cnt_d = cnt_q - CNT_W'(1);
        if (last_step) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else begin
          busy_d = 1'b1;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments only. Every flop
  // samples its pre-edge value, independent of the order of the statements.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      cnt_q   <= '0;
      mode_q  <= OP_HOLD;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign A    = a_q;
  assign SOL  = a_q[WIDTH-1];
  assign SOR  = a_q[0];
  assign busy = busy_q;
  assign done = done_q;

  // ---------------------------------------------------------------------------
  // Design invariants
  // ---------------------------------------------------------------------------
  // busy is a registered copy of "in RUN". It is never high alongside done,
  // because done only rises on the edge that leaves RUN or skips it.
  a_busy_tracks_state: assert property (
    @(posedge clk) disable iff (!rstn) busy_q == (state_q == ST_RUN)
  );

  a_busy_done_exclusive: assert property (
    @(posedge clk) disable iff (!rstn) !(busy_q && done_q)
  );

  a_run_count_nonzero: assert property (
    @(posedge clk) disable iff (!rstn) (state_q == ST_RUN) |-> (cnt_q != '0)
  );

endmodule

// File: tb/tb_univ_shift_reg_ctl.sv
// -----------------------------------------------------------------------------
// tb_univ_shift_reg_ctl
//
// Self-checking bench for univ_shift_reg_ctl (WIDTH=8, CNT_W=4). Each applied
// cycle pushes its expected A/busy/done onto a scoreboard queue. The entry is
// popped and compared #1 after the clock edge that produces the result.
// -----------------------------------------------------------------------------
module tb_univ_shift_reg_ctl;

  localparam int WIDTH = 8;
  localparam int CNT_W = 4;

  logic             clk;
  logic             rstn;
  logic [2:0]       mode;
  logic             en;
  logic             start;
  logic [CNT_W-1:0] count;
  logic [WIDTH-1:0] I;
  logic             SIL;
  logic             SIR;
  logic [WIDTH-1:0] A;
  logic             SOL;
  logic             SOR;
  logic             busy;
  logic             done;

  univ_shift_reg_ctl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rstn  (rstn),
    .mode  (mode),
    .en    (en),
    .start (start),
    .count (count),
    .I     (I),
    .SIL   (SIL),
    .SIR   (SIR),
    .A     (A),
    .SOL   (SOL),
    .SOR   (SOR),
    .busy  (busy),
    .done  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [7:0] a;
    logic       busy;
    logic       done;
  } exp_t;

  typedef struct {
    string      name;
    logic [2:0] mode;
    logic       en;
    logic       start;
    logic [3:0] count;
    logic [7:0] i;
    logic       sil;
    logic       sir;
    logic [7:0] exp_a;
    logic       exp_busy;
    logic       exp_done;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[20];

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_state(input exp_t e);
    check({e.name, " A"},    32'(A),    32'(e.a));
    check({e.name, " SOL"},  32'(SOL),  32'(e.a[7]));
    check({e.name, " SOR"},  32'(SOR),  32'(e.a[0]));
    check({e.name, " busy"}, 32'(busy), 32'(e.busy));
    check({e.name, " done"}, 32'(done), 32'(e.done));
  endtask

  // Drive one cycle of inputs, queue the expectation, wait for the edge,
  // then pop and compare.
  task automatic step(input string name, input logic [2:0] m, input logic e,
                      input logic st, input logic [3:0] c, input logic [7:0] i,
                      input logic sl, input logic sr,
                      input logic [7:0] ea, input logic eb, input logic ed);
    exp_t x;
    mode = m; en = e; start = st; count = c; I = i; SIL = sl; SIR = sr;
    x.name = name; x.a = ea; x.busy = eb; x.done = ed;
    sb.push_back(x);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      check({name, " scoreboard"}, 32'd0, 32'd1);
    end else begin
      x = sb.pop_front();
      check_state(x);
    end
  endtask

  function automatic vec_t mk(input string name, input logic [2:0] m, input logic e,
                              input logic st, input logic [3:0] c, input logic [7:0] i,
                              input logic sl, input logic sr,
                              input logic [7:0] ea, input logic eb, input logic ed);
    vec_t v;
    v.name = name; v.mode = m; v.en = e; v.start = st; v.count = c; v.i = i;
    v.sil = sl; v.sir = sr; v.exp_a = ea; v.exp_busy = eb; v.exp_done = ed;
    return v;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    logic [7:0] r;
    r = v;
    for (int k = 0; k < n; k++) r = {r[6:0], r[7]};
    return r;
  endfunction

  initial begin
    exp_t rst_exp;

    rstn = 1'b0; mode = 3'b000; en = 1'b0; start = 1'b0; count = '0;
    I = '0; SIL = 1'b0; SIR = 1'b0;

    // Single ops, start filtering and a short burst. The state carries over
    // from row to row.
    vecs[0]  = mk("load_a5",      3'b110, 1, 0, 4'd0, 8'hA5, 0, 0, 8'hA5, 0, 0);
    vecs[1]  = mk("shl_sil1",     3'b001, 1, 0, 4'd0, 8'h00, 1, 0, 8'h4B, 0, 0);
    vecs[2]  = mk("load_96",      3'b110, 1, 0, 4'd0, 8'h96, 0, 0, 8'h96, 0, 0);
    vecs[3]  = mk("asr_96",       3'b101, 1, 0, 4'd0, 8'h00, 0, 0, 8'hCB, 0, 0);
    vecs[4]  = mk("en0_hold",     3'b001, 0, 0, 4'd0, 8'h00, 1, 1, 8'hCB, 0, 0);
    vecs[5]  = mk("mode0_hold",   3'b000, 1, 0, 4'd0, 8'h00, 1, 1, 8'hCB, 0, 0);
    vecs[6]  = mk("mode7_hold",   3'b111, 1, 0, 4'd0, 8'hFF, 1, 1, 8'hCB, 0, 0);
    vecs[7]  = mk("shr_sir0",     3'b010, 1, 0, 4'd0, 8'h00, 1, 0, 8'h65, 0, 0);
    vecs[8]  = mk("ror_65",       3'b100, 1, 0, 4'd0, 8'h00, 0, 0, 8'hB2, 0, 0);
    vecs[9]  = mk("rol_b2",       3'b011, 1, 0, 4'd0, 8'h00, 0, 0, 8'h65, 0, 0);
    vecs[10] = mk("start_load",   3'b110, 1, 1, 4'd5, 8'h3C, 0, 0, 8'h3C, 0, 0);
    vecs[11] = mk("start_ld_en0", 3'b110, 0, 1, 4'd5, 8'h11, 0, 0, 8'h3C, 0, 0);
    vecs[12] = mk("load_81",      3'b110, 1, 0, 4'd0, 8'h81, 0, 0, 8'h81, 0, 0);
    vecs[13] = mk("rol3_start",   3'b011, 1, 1, 4'd3, 8'hFF, 0, 0, 8'h81, 1, 0);
    vecs[14] = mk("rol3_s1",      3'b000, 0, 0, 4'd0, 8'h00, 0, 0, 8'h03, 1, 0);
    vecs[15] = mk("rol3_s2",      3'b000, 0, 0, 4'd0, 8'h00, 0, 0, 8'h06, 1, 0);
    vecs[16] = mk("rol3_s3",      3'b000, 0, 0, 4'd0, 8'h00, 0, 0, 8'h0C, 0, 1);
    vecs[17] = mk("rol3_after",   3'b000, 0, 0, 4'd0, 8'h00, 0, 0, 8'h0C, 0, 0);
    vecs[18] = mk("cnt0_start",   3'b001, 1, 1, 4'd0, 8'h00, 1, 0, 8'h0C, 0, 1);
    vecs[19] = mk("cnt0_after",   3'b000, 0, 0, 4'd0, 8'h00, 0, 0, 8'h0C, 0, 0);

    // Reset state, with clocks running while rstn is held low.
    repeat (2) @(posedge clk);
    #1;
    rst_exp.name = "reset"; rst_exp.a = 8'h00; rst_exp.busy = 1'b0; rst_exp.done = 1'b0;
    check_state(rst_exp);
    rstn = 1'b1;

    for (int v = 0; v < 20; v++) begin
      step(vecs[v].name, vecs[v].mode, vecs[v].en, vecs[v].start, vecs[v].count,
           vecs[v].i, vecs[v].sil, vecs[v].sir,
           vecs[v].exp_a, vecs[v].exp_busy, vecs[v].exp_done);
    end

    // Asynchronous reset between edges clears A with no clock edge.
    #2;
    rstn = 1'b0;
    #1;
    rst_exp.name = "async_rst";
    check_state(rst_exp);
    @(posedge clk);
    #1;
    rstn = 1'b1;

    // shr burst with churning inputs. Only SIR matters while RUN.
    step("churn_load",  3'b110, 1, 0, 4'd0, 8'hF0, 0, 0, 8'hF0, 0, 0);
    step("churn_start", 3'b010, 0, 1, 4'd4, 8'h00, 0, 1, 8'hF0, 1, 0);
    step("churn_s1",    3'b110, 1, 1, 4'd9, 8'h00, 0, 1, 8'hF8, 1, 0);
    step("churn_s2",    3'b011, 1, 1, 4'd2, 8'hFF, 1, 0, 8'h7C, 1, 0);
    step("churn_s3",    3'b000, 0, 0, 4'd0, 8'h55, 0, 1, 8'hBE, 1, 0);
    step("churn_s4",    3'b101, 1, 1, 4'd1, 8'hAA, 1, 1, 8'hDF, 0, 1);
    // Back-to-back: start in the done cycle is accepted, and done drops.
    step("b2b_start",   3'b011, 0, 1, 4'd1, 8'h00, 0, 0, 8'hDF, 1, 0);
    step("b2b_s1",      3'b000, 0, 0, 4'd0, 8'h00, 0, 0, 8'hBF, 0, 1);
    step("b2b_after",   3'b000, 0, 0, 4'd0, 8'h00, 0, 0, 8'hBF, 0, 0);

    // A rol by WIDTH returns the original value.
    step("rol8_load",  3'b110, 1, 0, 4'd0, 8'h5A, 0, 0, 8'h5A, 0, 0);
    step("rol8_start", 3'b011, 0, 1, 4'd8, 8'h00, 0, 0, 8'h5A, 1, 0);
    for (int k = 1; k <= 8; k++) begin
      step($sformatf("rol8_s%0d", k), 3'b000, 0, 0, 4'd0, 8'h00, 0, 0,
           rotl8(8'h5A, k), (k < 8), (k == 8));
    end

    // Reset mid-burst aborts the burst with no done pulse.
    step("ror7_load",  3'b110, 1, 0, 4'd0, 8'h01, 0, 0, 8'h01, 0, 0);
    step("ror7_start", 3'b100, 0, 1, 4'd7, 8'h00, 0, 0, 8'h01, 1, 0);
    step("ror7_s1",    3'b000, 0, 0, 4'd0, 8'h00, 0, 0, 8'h80, 1, 0);
    step("ror7_s2",    3'b000, 0, 0, 4'd0, 8'h00, 0, 0, 8'h40, 1, 0);
    step("ror7_s3",    3'b000, 0, 0, 4'd0, 8'h00, 0, 0, 8'h20, 1, 0);
    #1;
    rstn = 1'b0;
    #1;
    rst_exp.name = "midburst_rst";
    check_state(rst_exp);
    @(posedge clk);
    #1;
    rstn = 1'b1;
    step("post_rst_1", 3'b000, 0, 0, 4'd0, 8'h00, 0, 0, 8'h00, 0, 0);
    step("post_rst_2", 3'b000, 0, 0, 4'd0, 8'h00, 0, 0, 8'h00, 0, 0);
    step("post_start", 3'b001, 0, 1, 4'd2, 8'h00, 1, 0, 8'h00, 1, 0);
    step("post_s1",    3'b000, 0, 0, 4'd0, 8'h00, 1, 0, 8'h01, 1, 0);
    step("post_s2",    3'b000, 0, 0, 4'd0, 8'h00, 1, 0, 8'h03, 0, 1);

    check("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/univ_shift_reg_ctl.md
Name: univ_shift_reg_ctl

Overview:
- Parametrised universal shift register with a built-in burst controller.
- Supports single-step shift, rotate and load operations.
- A start/count interface performs an N-bit shift autonomously, one bit per clock, with busy/done status.
- Used as the serial/parallel conversion and bit-alignment stage in datapaths that need multi-bit shifts without an external sequencer.

Parameters:
WIDTH, 8, register width in bits (WIDTH >= 2)
CNT_W, 4, width of burst count input; 2^CNT_W - 1 is the max burst length

Ports:
clk  input  1  clock, all state updates on rising edge
rstn  input  1  asynchronous active-low reset
mode  input  3  operation select: 000 hold, 001 shl, 010 shr logical, 011 rol, 100 ror, 101 asr, 110 parallel load, 111 hold (reserved)
en  input  1  single-step enable; performs mode op once per clock while IDLE
start  input  1  burst request; sampled only in IDLE
count  input  CNT_W  burst length, captured with start
I  input  WIDTH  parallel load data
SIL  input  1  serial in for shl (enters A[0])
SIR  input  1  serial in for shr (enters A[WIDTH-1])
A  output  WIDTH  register contents
SOL  output  1  A[WIDTH-1], combinational
SOR  output  1  A[0], combinational
busy  output  1  high while burst running
done  output  1  one-cycle pulse after burst completes

Behaviour:
- Reset (rstn=0, asynchronous): A=0, state IDLE, busy=0, done=0, internal count and latched mode cleared. A reset asserted mid-burst aborts the burst, and no done pulse is produced.
- Operations, applied on a clock edge:
  - shl: A <= {A[WIDTH-2:0], SIL}
  - shr: A <= {SIR, A[WIDTH-1:1]}
  - rol: A <= {A[WIDTH-2:0], A[WIDTH-1]}
  - ror: A <= {A[0], A[WIDTH-1:1]}
  - asr: A <= {A[WIDTH-1], A[WIDTH-1:1]}
  - load: A <= I
  - hold / 111: A unchanged
- FSM states: IDLE, RUN.
- IDLE:
  - start=1, mode in 001..101, count!=0: latch mode and count, go to RUN, busy <= 1. A is unchanged in this cycle.
  - start=1, mode in 001..101, count==0: stay IDLE, A unchanged, done <= 1 for the next cycle.
  - start=1 with mode 000/110/111: start is ignored and en is evaluated normally.
  - else en=1: perform mode op once. en=0: A holds.
  - A valid start has priority over en in the same cycle.
- RUN:
  - Each clock performs the latched op once and decrements the remaining count.
  - The edge that performs the last shift returns the FSM to IDLE, with busy <= 0 and done <= 1.
  - Timing: with start sampled at edge k, shifts occur at edges k+1..k+count; busy is high after k through k+count; done is high between edges k+count and k+count+1.
  - mode, en, start, count and I are ignored in RUN.
  - SIL/SIR are sampled live at every shift edge.
- done is registered, exactly one cycle wide, and deasserts at the following edge even if a new start is accepted there.
- Back-to-back bursts: a start in the cycle where done=1 (FSM already IDLE) is accepted.
- count may exceed WIDTH:
  - shl/shr then fill the register entirely with serial-in history.
  - rol/ror by WIDTH returns the original value.
  - asr saturates to all-sign bits.
- SOL/SOR always reflect the current A; there is no extra latency.

Test Plan:
- Reset: drive arbitrary ops, assert rstn=0 asynchronously between edges -> A=00, busy=0, done=0 immediately without a clock.
- Single-step: load I=8'hA5 (mode 110, en=1), then shl with SIL=1 -> A=8'h4B, SOL=0, SOR=1; then asr from 8'h96 -> 8'hCB.
- Burst rol: A=8'h81, mode 011, start=1, count=3 -> busy high 3 cycles, A=8'h03,06,0C, done single pulse after 3rd shift, busy low same cycle.
- Burst with input churn: A=8'hF0, shr, count=4, SIR toggling 1,0,1,1 while mode/en/start/I change during RUN -> A=8'hDF (shr 4 with SIR=1,0,1,1; first-shifted bit ends lowest of the four upper bits), inputs ignored, no extra operations.
- Boundaries:
  - start with count=0 -> done pulse next cycle, busy never high, A unchanged.
  - start with mode 110 -> ignored; en=1 loads I.
  - rol count=8 on 8'h5A -> A=8'h5A.
- Reset mid-burst: ror count=7, assert rstn after 3 shifts -> A=00, IDLE, no done; next start accepted normally.
